// File: rtl/prog_ram_loader_if.sv
// Nibble-stream in, program-memory write port out, plus load status.
// master = producer/controller side, slave = the loader.
interface prog_ram_loader_if;
    logic        start;
    logic        in_valid;
    logic [3:0]  in_nib;
    logic        in_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        done;
    logic [7:0]  nib_sum;

    modport master (
        output start, in_valid, in_nib,
        input  in_ready, wr_en, wr_addr, wr_data, done, nib_sum
    );

    modport slave (
        input  start, in_valid, in_nib,
        output in_ready, wr_en, wr_addr, wr_data, done, nib_sum
    );
endinterface

// File: rtl/prog_ram_loader.sv
// Packs 8 nibbles per 32-bit word and writes NUM_WORDS words to program RAM,
// keeping a running modulo-256 nibble sum for the load.
module prog_ram_loader #(
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned ADDR_STEP = 4
) (
    input logic              clk,
    input logic              rst,
    prog_ram_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    localparam logic [1:0] LAST_IDX = 2'(NUM_WORDS - 1);

    state_t      state;
    logic [1:0]  word_idx;
    logic [2:0]  nib_cnt;
    logic [31:0] pack;
    logic [31:0] pack_next;
    logic [3:0]  addr_next;
    logic        accept;

    // pack_next already holds the 8th nibble, so WRITE can present it directly
    always_comb begin
        pack_next = pack;
        pack_next[{nib_cnt, 2'b00} +: 4] = bus.in_nib;
        addr_next = 4'(32'(word_idx) * ADDR_STEP);
        accept    = bus.in_valid && bus.in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            word_idx     <= '0;
            nib_cnt      <= '0;
            pack         <= '0;
            bus.in_ready <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            bus.done     <= 1'b0;
            bus.nib_sum  <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state        <= COLLECT;
                        word_idx     <= '0;
                        nib_cnt      <= '0;
                        pack         <= '0;
                        bus.nib_sum  <= '0;
                        bus.in_ready <= 1'b1;
                        bus.done     <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        pack        <= pack_next;
                        nib_cnt     <= nib_cnt + 3'd1;
                        bus.nib_sum <= bus.nib_sum + {4'b0000, bus.in_nib};
                        if (nib_cnt == 3'd7) begin
                            state        <= WRITE;
                            bus.in_ready <= 1'b0;
                            bus.wr_en    <= 1'b1;
                            bus.wr_addr  <= addr_next;
                            bus.wr_data  <= pack_next;
                        end
                    end
                end
                WRITE: begin
                    if (word_idx == LAST_IDX) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        word_idx     <= word_idx + 2'd1;
                        state        <= COLLECT;
                        bus.in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_ram_loader.sv
// Scoreboard bench for prog_ram_loader: expected writes are queued as nibbles
// are accepted and matched against each wr_en strobe.
module tb_prog_ram_loader;
    localparam int unsigned ADDR_STEP = 4;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    logic clk;
    logic rst;
    prog_ram_loader_if bus ();

    prog_ram_loader #(.NUM_WORDS(4), .ADDR_STEP(ADDR_STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned pcyc   = 0;
    exp_t        sb[$];

    int unsigned m_idx;
    int unsigned m_k;
    logic [31:0] m_word;
    logic [7:0]  m_sum;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_wr_en"},    bus.wr_en,    0);
        chk({tag, "_wr_addr"},  bus.wr_addr,  0);
        chk({tag, "_wr_data"},  bus.wr_data,  0);
        chk({tag, "_done"},     bus.done,     0);
        chk({tag, "_nib_sum"},  bus.nib_sum,  0);
    endtask

    task automatic model_restart();
        m_idx  = 0;
        m_k    = 0;
        m_word = '0;
        m_sum  = '0;
    endtask

    task automatic model_accept(input logic [3:0] n, input int unsigned c);
        exp_t e;
        m_sum = m_sum + {4'b0000, n};
        m_word[4*m_k +: 4] = n;
        m_k++;
        if (m_k == 8) begin
            e.addr = 4'(m_idx * ADDR_STEP);
            e.data = m_word;
            e.cyc  = c;
            sb.push_back(e);
            m_idx++;
            m_k    = 0;
            m_word = '0;
        end
    endtask

    // Offer one nibble until accepted; in_ready is stable at the falling edge
    task automatic feed(input logic [3:0] n, input bit pulse_start = 1'b0);
        bit          acc;
        int unsigned c;
        acc = 1'b0;
        c   = 0;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_nib   = n;
            bus.start    = pulse_start;
            acc = bus.in_ready;
            c   = pcyc;
            @(posedge clk);
            #1 bus.start = 1'b0;
        end
        if (!acc) chk("feed_timeout", 0, 1);
        else      model_accept(n, c);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        model_restart();
        chk("start_ready", bus.in_ready, 1);
        chk("start_done",  bus.done,     0);
        chk("start_sum",   bus.nib_sum,  0);
    endtask

    task automatic finish_load(input logic [7:0] exp_sum);
        @(negedge clk);
        chk("done_early", bus.done, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("done_lat",   bus.done,     1);
        chk("done_ready", bus.in_ready, 0);
        chk("done_wr_en", bus.wr_en,    0);
        chk("done_sum",   bus.nib_sum,  exp_sum);
        chk("load_sb",    sb.size(),    0);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                chk("wr_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", bus.wr_addr, e.addr);
                chk("wr_data", bus.wr_data, e.data);
                chk("wr_lat",  pcyc,        e.cyc + 1);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_nib   = '0;
        rst          = 1'b0;
        model_restart();

        // Power-on reset takes effect before any clock edge
        #2 rst = 1'b1;
        #2 check_zero("por");
        repeat (2) @(negedge clk);

        // start coinciding with the first edge after reset release
        bus.start = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        model_restart();
        chk("rst_start_ready", bus.in_ready, 1);
        for (int k = 0; k < 8; k++) feed(4'(k));
        chk("w0_sum", bus.nib_sum, 28);
        for (int k = 0; k < 8; k++) feed(4'(k + 9));
        for (int k = 0; k < 3; k++) feed(4'(k + 5));

        // Asynchronous reset between edges mid-load
        #2 rst = 1'b1;
        bus.in_valid = 1'b0;
        #1 check_zero("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_ready", bus.in_ready, 0);
        chk("post_rst_sb",    sb.size(),    0);

        // Full load of 0xF with a stray start after 3 nibbles
        do_start();
        for (int k = 0; k < 32; k++) feed(4'hF, k == 3);
        finish_load(8'hE0);
        idle(3);
        chk("done_hold", bus.done, 1);

        // Restart from DONE, word 0 with in_valid toggling, then random words
        do_start();
        for (int k = 0; k < 8; k++) begin
            feed(4'(k + 1));
            idle(1);
        end
        for (int k = 0; k < 24; k++) feed(4'($urandom_range(0, 15)));
        finish_load(m_sum);
        idle(2);
        chk("final_sb", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
